// File: rtl/grid_streamer.sv
// Streams a binary canvas out of a 1-bit synchronous memory as one byte per pixel,
// in row-major order under valid/ready flow control, counting the set pixels.
module grid_streamer #(
   parameter int unsigned GRID_SIZE  = 28,
   parameter int unsigned NUM_PIXELS = 784,
   parameter logic [7:0]  ON_VALUE   = 8'hFF,
   parameter logic [7:0]  OFF_VALUE  = 8'h00
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   output logic       mem_rd,
   output logic [9:0] mem_addr,
   input  logic       mem_rdata,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [9:0] out_index,
   output logic       out_last,
   output logic       busy,
   output logic       done,
   output logic [9:0] pop_count
);

   // A zero NUM_PIXELS falls back to the square canvas.
   localparam int unsigned FRAME_PIXELS = (NUM_PIXELS > 0) ? NUM_PIXELS : GRID_SIZE * GRID_SIZE;
   localparam logic [9:0]  LAST_IDX     = 10'(FRAME_PIXELS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] index_q, index_d;
   logic [9:0] count_q, count_d;
   logic [7:0] data_q, data_d;
   logic [9:0] oidx_q, oidx_d;
   logic [9:0] pop_q, pop_d;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         index_q <= '0;
         count_q <= '0;
         data_q  <= OFF_VALUE;
         oidx_q  <= '0;
         pop_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         count_q <= count_d;
         data_q  <= data_d;
         oidx_q  <= oidx_d;
         pop_q   <= pop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      count_d = count_q;
      data_d  = data_q;
      oidx_d  = oidx_q;
      pop_d   = pop_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               index_d = '0;
               count_d = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = CAPTURE;
         CAPTURE: begin
            // Memory answers one cycle after the read issued in FETCH.
            data_d  = mem_rdata ? ON_VALUE : OFF_VALUE;
            oidx_d  = index_q;
            count_d = count_q + {9'd0, mem_rdata};
            state_d = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (index_q == LAST_IDX) begin
                  state_d = FINISH;
               end else begin
                  index_d = index_q + 10'd1;
                  state_d = FETCH;
               end
            end
         end
         FINISH: begin
            pop_d   = count_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_rd    = (state_q == FETCH);
   assign mem_addr  = index_q;
   assign out_valid = (state_q == SEND);
   assign out_data  = data_q;
   assign out_index = oidx_q;
   assign out_last  = out_valid && (oidx_q == LAST_IDX);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign pop_count = pop_q;

endmodule

// File: tb/tb_grid_streamer.sv
// Bench for grid_streamer: canvas memory model, per-frame stream scoreboard,
// flow-control stability, restart/collision/reset corner cases.
module tb_grid_streamer;

   localparam int N = 784;

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       mem_rd;
   logic [9:0] mem_addr;
   logic       mem_rdata = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [9:0] out_index;
   logic       out_last;
   logic       busy;
   logic       done;
   logic [9:0] pop_count;

   logic canvas [N];
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      string name;
      int    pattern;     // 0 clear, 1 three pixels, 2 all set, 3 checker, 4 random
      int    ready_mode;  // 0 always ready, 1 random ready
      int    restart_at;  // transfer count at which start is re-pulsed, -1 none
      int    collide;     // pulse start on the done cycle
      int    exp_pop;     // -1: take from reference model
      int    exp_cycles;  // start->done cycles, -1: not checked
   } vec_t;

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) if (mem_rd) mem_rdata <= canvas[mem_addr];

   grid_streamer dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .start    (start),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_index(out_index),
      .out_last (out_last),
      .busy     (busy),
      .done     (done),
      .pop_count(pop_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic int model_pop();
      int s = 0;
      for (int i = 0; i < N; i++) s += canvas[i] ? 1 : 0;
      return s;
   endfunction

   task automatic fill(input int pattern);
      for (int i = 0; i < N; i++) begin
         case (pattern)
            0:       canvas[i] = 1'b0;
            1:       canvas[i] = (i == 0 || i == 405 || i == 783);
            2:       canvas[i] = 1'b1;
            3:       canvas[i] = ((i % 2) == 1);
            default: canvas[i] = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " mem_rd"}, int'(mem_rd), 0);
      check({tag, " mem_addr"}, int'(mem_addr), 0);
      check({tag, " out_valid"}, int'(out_valid), 0);
      check({tag, " out_data"}, int'(out_data), 0);
      check({tag, " out_index"}, int'(out_index), 0);
      check({tag, " out_last"}, int'(out_last), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " done"}, int'(done), 0);
      check({tag, " pop_count"}, int'(pop_count), 0);
   endtask

   // Called #1 after an edge with the DUT idle; the current cycle is start cycle 0.
   task automatic run_frame(input string tag, input int ready_mode, input int restart_at,
                            input int collide, input int abort_at, input int exp_pop_in,
                            input int exp_cycles);
      int xfers = 0, bad_data = 0, bad_idx = 0, bad_last = 0, unstable = 0;
      int dones = 0, busy_gaps = 0, first_valid = -1, cyc = 0, pop_changed = 0, reads = 0;
      int pop_before, exp_pop;
      bit hold = 0, restarted = 0;
      logic [7:0] hold_d, exp_d;
      logic [9:0] hold_i;
      exp_pop    = (exp_pop_in >= 0) ? exp_pop_in : model_pop();
      pop_before = int'(pop_count);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc < 20000) begin
         if (hold && (!out_valid || out_data !== hold_d || out_index !== hold_i)) unstable++;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_last !== (out_valid && out_index == 10'(N - 1))) bad_last++;
         if (!busy) busy_gaps++;
         if (mem_rd) reads++;
         if (int'(pop_count) != pop_before) pop_changed++;
         if (done) begin
            dones++;
            if (collide != 0) start = 1'b1;
            break;
         end
         start = 1'b0;
         out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            exp_d = canvas[xfers] ? 8'hFF : 8'h00;
            if (out_data !== exp_d) bad_data++;
            if (int'(out_index) != xfers) bad_idx++;
            xfers++;
            hold = 0;
         end else if (out_valid) begin
            hold = 1;
            hold_d = out_data;
            hold_i = out_index;
         end else begin
            hold = 0;
         end
         if (restart_at >= 0 && !restarted && xfers == restart_at) begin
            start = 1'b1;
            restarted = 1;
         end
         if (abort_at >= 0 && xfers == abort_at) return;
         tick();
         cyc++;
      end
      check({tag, " done seen once"}, dones, 1);
      check({tag, " transfers"}, xfers, N);
      check({tag, " bad bytes"}, bad_data, 0);
      check({tag, " bad indices"}, bad_idx, 0);
      check({tag, " out_last errors"}, bad_last, 0);
      check({tag, " unstable while stalled"}, unstable, 0);
      check({tag, " busy gaps"}, busy_gaps, 0);
      check({tag, " mem reads"}, reads, N);
      check({tag, " pop_count early change"}, pop_changed, 0);
      check({tag, " first out_valid latency"}, first_valid, 3);
      if (exp_cycles >= 0) check({tag, " start to done cycles"}, cyc, exp_cycles);
      tick();
      start = 1'b0;
      check({tag, " pop_count"}, int'(pop_count), exp_pop);
      check({tag, " done one cycle"}, int'(done), 0);
      check({tag, " idle after frame"}, int'(busy), 0);
      if (collide != 0) begin
         tick();
         check({tag, " collision start ignored"}, int'(busy), 0);
         check({tag, " collision no fetch"}, int'(mem_rd), 0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"clear",   0, 0, -1, 1, 0,   2353};
      vecs[1] = '{"three",   1, 0, -1, 0, 3,   2353};
      vecs[2] = '{"allset",  2, 0, -1, 0, 784, 2353};
      vecs[3] = '{"checker", 3, 1, -1, 0, 392, -1};
      vecs[4] = '{"random",  4, 1, -1, 0, -1,  -1};
      vecs[5] = '{"restart", 4, 0, 100, 0, -1, 2353};

      fill(0);
      tick();
      tick();
      check_reset_outputs("reset");
      resetn = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("idle before start busy", int'(busy), 0);
      check("idle before start valid", int'(out_valid), 0);

      for (int v = 0; v < 6; v++) begin
         fill(vecs[v].pattern);
         run_frame(vecs[v].name, vecs[v].ready_mode, vecs[v].restart_at, vecs[v].collide,
                   -1, vecs[v].exp_pop, vecs[v].exp_cycles);
         tick();
      end

      // Reset in the middle of a frame, at pixel 500.
      fill(2);
      run_frame("abort", 0, -1, 0, 500, -1, -1);
      tick();
      check("abort reached index 500", int'(mem_addr), 500);
      #2 resetn = 1'b0;
      #1 check_reset_outputs("midframe reset");
      tick();
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("no resume after reset busy", int'(busy), 0);
      check("no resume after reset valid", int'(out_valid), 0);
      fill(4);
      run_frame("after reset", 0, -1, 0, -1, -1, 2353);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_streamer.md
GRID_STREAMER -- requirements
Module: grid_streamer

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 28, meaning canvas edge length in pixels.
REQ-002 SHALL have parameter NUM_PIXELS, default 784, meaning pixels per frame (GRID_SIZE*GRID_SIZE).
REQ-003 SHALL have parameter ON_VALUE, default 8'hFF, meaning output byte for a set pixel.
REQ-004 SHALL have parameter OFF_VALUE, default 8'h00, meaning output byte for a clear pixel.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: CLOCK_50  input  1  system clock; resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have the port start  input  1  single-cycle request to read out one frame.
REQ-007 SHALL have the port mem_rd  output  1  canvas memory read enable.
REQ-008 SHALL have the port mem_addr  output  10  canvas read address, row-major (y*GRID_SIZE+x).
REQ-009 SHALL have the port mem_rdata  input  1  canvas pixel; valid on the cycle after mem_rd.
REQ-010 SHALL have the port out_valid  output  1  pixel byte available.
REQ-011 SHALL have the port out_ready  input  1  downstream (NN input) accepts the byte.
REQ-012 SHALL have the port out_data  output  8  pixel byte, ON_VALUE or OFF_VALUE.
REQ-013 SHALL have the port out_index  output  10  index of the pixel in out_data.
REQ-014 SHALL have the port out_last  output  1  high with out_valid when out_index==NUM_PIXELS-1.
REQ-015 SHALL have the port busy  output  1  readout in progress.
REQ-016 SHALL have the port done  output  1  one-cycle pulse on frame completion.
REQ-017 SHALL have the port pop_count  output  10  number of set pixels in the last completed frame.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, CAPTURE, SEND and FINISH.
REQ-019 SHALL move IDLE->FETCH when start=1; the pixel index SHALL be 0 and the running count 0.
REQ-020 SHALL assert mem_rd=1 with mem_addr=index in FETCH only, then go to CAPTURE; mem_rd SHALL be 0 in every other state.
REQ-021 SHALL register mem_rdata in CAPTURE: out_data<=ON_VALUE if 1 else OFF_VALUE, out_index<=index, count+=mem_rdata; next state SEND.
REQ-022 SHALL hold out_valid=1 in SEND, with out_data, out_index and out_last stable, until out_valid&&out_ready.
REQ-023 SHALL, on transfer in SEND, go to FINISH if index==NUM_PIXELS-1; otherwise index+1 and go to FETCH.
REQ-024 SHALL pulse done=1 for exactly one cycle in FINISH, load pop_count with the final count, and return to IDLE.
REQ-025 SHALL give a minimum throughput of one byte per 3 cycles with out_ready held high; start-to-first-out_valid latency SHALL be 3 cycles.
REQ-026 SHALL assert busy=1 in every state except IDLE.
REQ-027 SHALL ignore start when not in IDLE; no restart and no queuing.
REQ-028 SHALL keep out_valid low in all states except SEND; out_ready outside SEND SHALL have no effect.
REQ-029 SHALL keep the count at 10 bits; its maximum is 784 with no overflow. pop_count SHALL change only in FINISH.
REQ-030 SHALL, when start and the FINISH->IDLE transition fall on the same cycle, ignore that start; a start is accepted only while in IDLE.

Reset
REQ-031 SHALL, on resetn=0 at any time including mid-frame, immediately force IDLE, index=0, count=0, mem_rd=0, mem_addr=0, out_valid=0, out_data=OFF_VALUE, out_index=0, out_last=0, busy=0, done=0 and pop_count=0.
REQ-032 SHALL, after reset release, stay in IDLE until the next start; a partially streamed frame is not resumed.

Verification
REQ-033 SHALL cover all-clear canvas, start, out_ready=1: 784 bytes 0x00, indices 0..783, out_last only at 783, done once, pop_count=0, 784*3+1 cycles start->done.
REQ-034 SHALL cover canvas with pixels 0, 405 (x=13,y=14) and 783 set: bytes 0xFF at exactly those indices, pop_count=3.
REQ-035 SHALL cover out_ready toggled randomly: no byte lost or duplicated, and out_data/out_index stable while valid&&!ready.
REQ-036 SHALL cover start re-pulsed at byte 100: stream unaffected, still one done, busy continuous.
REQ-037 SHALL cover resetn asserted at index 500: all outputs at reset values in the same cycle; a new start restreams from index 0.
REQ-038 SHALL cover all-set canvas: pop_count=784, every byte 0xFF.
